// File: rtl/musb_trace_buffer_pkg.sv
// Shared types for the writeback trace buffer.
// State encoding and trace entry layout.
package musb_trace_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam int GPR_AW = 5;

    function automatic int entry_width(input int dw);
        return 2 * dw + GPR_AW;
    endfunction

endpackage

// File: rtl/musb_trace_ram.sv
// Trace storage: simple dual-port RAM.
// Synchronous write, registered read; a same-slot read sees old data.
module musb_trace_ram #(
    parameter int AW = 4,
    parameter int W  = 69
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/musb_trace_buffer.sv
// Writeback trace buffer: circular capture of GPR writes
// with PC-match trigger and post-trigger window.
module musb_trace_buffer
    import musb_trace_buffer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FILTER_R0  = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  evt_valid,
    input  logic [DATA_WIDTH-1:0] evt_pc,
    input  logic [4:0]            evt_wa,
    input  logic [DATA_WIDTH-1:0] evt_wd,
    input  logic                  evt_we,
    input  logic                  arm,
    input  logic                  disarm,
    input  logic                  trig_en,
    input  logic [DATA_WIDTH-1:0] trig_pc,
    input  logic [CNT_WIDTH-1:0]  post_count,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_pc,
    output logic [4:0]            rd_wa,
    output logic [DATA_WIDTH-1:0] rd_wd,
    output logic [1:0]            state,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  wrapped,
    output logic [DEPTH_LOG2-1:0] trig_idx
);

    localparam int EW = entry_width(DATA_WIDTH);
    localparam int DW = DATA_WIDTH;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT =
        (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;

    trace_state_e          st_q, st_d;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] trig_slot;
    logic [CNT_WIDTH-1:0]  remain;
    logic [DEPTH_LOG2:0]   cnt_q;
    logic                  wrap_q;
    logic                  rd_ok;
    logic                  filt;
    logic                  cap;
    logic                  hit;
    logic                  rd_hit;
    logic [DEPTH_LOG2-1:0] oldest;
    logic [DEPTH_LOG2-1:0] rd_slot;
    logic [EW-1:0]         rdata;

    always_comb begin
        filt = (FILTER_R0 != 0) && (evt_wa == 5'd0);
        cap  = evt_valid && evt_we && !filt && !arm && !disarm
            && (st_q == ST_ARMED || st_q == ST_POST);
        hit  = cap && (st_q == ST_ARMED) && trig_en
            && (evt_pc == trig_pc);
        st_d = st_q;
        case (st_q)
            ST_ARMED: begin
                if (hit) begin
                    st_d = (post_count == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (cap && remain == CNT_WIDTH'(1)) begin
                    st_d = ST_DONE;
                end
            end
            default: st_d = st_q;
        endcase
        if (arm) begin
            st_d = ST_ARMED;
        end
        // Disarm dominates a simultaneous arm.
        if (disarm) begin
            st_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= ST_IDLE;
            wr_ptr    <= '0;
            cnt_q     <= '0;
            wrap_q    <= 1'b0;
            remain    <= '0;
            trig_slot <= '0;
            rd_valid  <= 1'b0;
            rd_ok     <= 1'b0;
        end else begin
            st_q     <= st_d;
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_ok <= rd_hit;
            end
            if (arm && !disarm) begin
                wr_ptr    <= '0;
                cnt_q     <= '0;
                wrap_q    <= 1'b0;
                remain    <= '0;
                trig_slot <= '0;
            end else if (cap) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (cnt_q == DEPTH_CNT) begin
                    wrap_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (hit) begin
                    remain    <= post_count;
                    trig_slot <= wr_ptr;
                end else if (st_q == ST_POST) begin
                    remain <= remain - 1'b1;
                end
            end
        end
    end

    // count mod DEPTH is just its low bits, so oldest needs no special case.
    assign oldest   = wr_ptr - cnt_q[DEPTH_LOG2-1:0];
    assign rd_slot  = oldest + rd_idx;
    assign rd_hit   = {1'b0, rd_idx} < cnt_q;
    assign trig_idx = trig_slot - oldest;

    musb_trace_ram #(
        .AW (DEPTH_LOG2),
        .W  (EW)
    ) u_ram (
        .clk   (clk),
        .we    (cap),
        .waddr (wr_ptr),
        .wdata ({evt_pc, evt_wa, evt_wd}),
        .re    (rd_en),
        .raddr (rd_slot),
        .rdata (rdata)
    );

    assign rd_pc   = rd_ok ? rdata[EW-1 -: DW]     : '0;
    assign rd_wa   = rd_ok ? rdata[DW+4 -: 5]      : '0;
    assign rd_wd   = rd_ok ? rdata[DW-1:0]         : '0;
    assign state   = st_q;
    assign count   = cnt_q;
    assign wrapped = wrap_q;

endmodule

// File: tb/tb_musb_trace_buffer.sv
// Directed bench for musb_trace_buffer with a read scoreboard.
module tb_musb_trace_buffer;

    localparam int DL = 3;
    localparam int DW = 32;
    localparam int CW = 16;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          evt_valid = 0;
    logic [DW-1:0] evt_pc = '0;
    logic [4:0]    evt_wa = '0;
    logic [DW-1:0] evt_wd = '0;
    logic          evt_we = 0;
    logic          arm = 0;
    logic          disarm = 0;
    logic          trig_en = 0;
    logic [DW-1:0] trig_pc = '0;
    logic [CW-1:0] post_count = '0;
    logic          rd_en = 0;
    logic [DL-1:0] rd_idx = '0;
    logic          rd_valid;
    logic [DW-1:0] rd_pc;
    logic [4:0]    rd_wa;
    logic [DW-1:0] rd_wd;
    logic [1:0]    state;
    logic [DL:0]   count;
    logic          wrapped;
    logic [DL-1:0] trig_idx;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t sb[$];

    musb_trace_buffer #(
        .DEPTH_LOG2 (DL),
        .DATA_WIDTH (DW),
        .FILTER_R0  (1),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .evt_valid  (evt_valid),
        .evt_pc     (evt_pc),
        .evt_wa     (evt_wa),
        .evt_wd     (evt_wd),
        .evt_we     (evt_we),
        .arm        (arm),
        .disarm     (disarm),
        .trig_en    (trig_en),
        .trig_pc    (trig_pc),
        .post_count (post_count),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_valid   (rd_valid),
        .rd_pc      (rd_pc),
        .rd_wa      (rd_wa),
        .rd_wd      (rd_wd),
        .state      (state),
        .count      (count),
        .wrapped    (wrapped),
        .trig_idx   (trig_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input int wa);
        ent_t e;
        e.pc = 32'h1000 + 32'(wa) * 4;
        e.wa = 5'(wa);
        e.wd = 32'hD000_0000 | 32'(wa);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1;
        tick();
        arm = 0;
    endtask

    task automatic set_evt(input ent_t e);
        evt_valid = 1;
        evt_we    = 1;
        evt_pc    = e.pc;
        evt_wa    = e.wa;
        evt_wd    = e.wd;
    endtask

    task automatic clr_evt();
        evt_valid = 0;
        evt_we    = 0;
    endtask

    task automatic evt(input ent_t e);
        set_evt(e);
        tick();
        clr_evt();
    endtask

    task automatic evt_pc_only(input logic [31:0] pc, input int wa);
        ent_t e;
        e    = mk(wa);
        e.pc = pc;
        evt(e);
    endtask

    task automatic start_read(input int idx, input ent_t e);
        sb.push_back(e);
        rd_en  = 1;
        rd_idx = DL'(idx);
    endtask

    task automatic check_read(input string tag);
        ent_t e;
        rd_en = 0;
        chk({tag, "_valid"}, 64'(rd_valid), 64'(1));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            e = sb.pop_front();
            chk({tag, "_pc"}, 64'(rd_pc), 64'(e.pc));
            chk({tag, "_wa"}, 64'(rd_wa), 64'(e.wa));
            chk({tag, "_wd"}, 64'(rd_wd), 64'(e.wd));
        end
    endtask

    task automatic rd(input string tag, input int idx, input ent_t e);
        start_read(idx, e);
        tick();
        check_read(tag);
    endtask

    initial begin
        ent_t z;
        ent_t p;
        z.pc = '0;
        z.wa = '0;
        z.wd = '0;

        // Reset state
        tick();
        tick();
        chk("rst_state", 64'(state), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_wrapped", 64'(wrapped), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_rd_pc", 64'(rd_pc), 64'(0));
        rst = 0;
        tick();

        // Five events, no trigger
        do_arm();
        chk("arm_state", 64'(state), 64'(1));
        for (int i = 1; i <= 5; i++) evt(mk(i));
        chk("five_count", 64'(count), 64'(5));
        chk("five_wrapped", 64'(wrapped), 64'(0));
        for (int i = 0; i < 5; i++) rd($sformatf("five_rd%0d", i), i, mk(i + 1));
        rd("beyond_count", 5, z);

        // Eleven events, wrap
        do_arm();
        chk("rearm_count", 64'(count), 64'(0));
        for (int i = 1; i <= 11; i++) evt(mk(i));
        chk("wrap_count", 64'(count), 64'(8));
        chk("wrap_flag", 64'(wrapped), 64'(1));
        rd("wrap_rd0", 0, mk(4));
        rd("wrap_rd7", 7, mk(11));

        // Trigger with post window of two
        trig_en    = 1;
        trig_pc    = 32'h100;
        post_count = 16'd2;
        do_arm();
        evt_pc_only(32'h0F8, 1);
        evt_pc_only(32'h0FC, 2);
        chk("pre_trig_state", 64'(state), 64'(1));
        evt_pc_only(32'h100, 3);
        chk("trig_state", 64'(state), 64'(2));
        evt_pc_only(32'h104, 4);
        chk("post1_state", 64'(state), 64'(2));
        evt_pc_only(32'h108, 5);
        chk("done_state", 64'(state), 64'(3));
        evt_pc_only(32'h10C, 6);
        chk("done_count", 64'(count), 64'(5));
        chk("done_trig_idx", 64'(trig_idx), 64'(2));
        p    = mk(3);
        p.pc = 32'h100;
        rd("trig_entry", 2, p);

        // Zero post window
        post_count = 16'd0;
        do_arm();
        evt_pc_only(32'h100, 7);
        chk("pc0_state", 64'(state), 64'(3));
        chk("pc0_count", 64'(count), 64'(1));
        chk("pc0_trig_idx", 64'(trig_idx), 64'(0));
        trig_en = 0;

        // R0 filter, arm/event and arm/disarm collisions
        do_arm();
        evt(mk(0));
        chk("r0_count", 64'(count), 64'(0));
        evt(mk(1));
        set_evt(mk(2));
        arm = 1;
        tick();
        arm = 0;
        clr_evt();
        chk("arm_evt_count", 64'(count), 64'(0));
        chk("arm_evt_state", 64'(state), 64'(1));
        arm    = 1;
        disarm = 1;
        tick();
        arm    = 0;
        disarm = 0;
        chk("arm_disarm_state", 64'(state), 64'(0));

        // Disarm keeps contents
        do_arm();
        for (int i = 1; i <= 3; i++) evt(mk(i));
        disarm = 1;
        tick();
        disarm = 0;
        chk("disarm_state", 64'(state), 64'(0));
        chk("disarm_count", 64'(count), 64'(3));
        evt(mk(9));
        chk("idle_nocap", 64'(count), 64'(3));
        rd("disarm_rd1", 1, mk(2));

        // Read of the slot being overwritten returns old data
        do_arm();
        for (int i = 1; i <= 8; i++) evt(mk(i));
        chk("full_wrapped", 64'(wrapped), 64'(0));
        set_evt(mk(9));
        start_read(0, mk(1));
        tick();
        clr_evt();
        check_read("rw_same");
        chk("rw_wrapped", 64'(wrapped), 64'(1));
        rd("rw_after", 7, mk(9));

        // Asynchronous reset while in POST
        trig_en    = 1;
        trig_pc    = 32'h200;
        post_count = 16'd3;
        do_arm();
        evt(mk(1));
        p    = mk(2);
        p.pc = 32'h200;
        set_evt(p);
        rd_en  = 1;
        rd_idx = '0;
        tick();
        clr_evt();
        rd_en = 0;
        chk("pre_rst_state", 64'(state), 64'(2));
        chk("pre_rst_rd_valid", 64'(rd_valid), 64'(1));
        rst = 1;
        #1;
        chk("async_rst_state", 64'(state), 64'(0));
        chk("async_rst_count", 64'(count), 64'(0));
        chk("async_rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("async_rst_rd_pc", 64'(rd_pc), 64'(0));
        tick();
        rst = 0;
        tick();
        chk("post_rst_state", 64'(state), 64'(0));
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
